mems_spi_arbiter: RTL and testbench

Shares the single MEMS DAC SPI master between two requesters: requester 0 is the scan sequencer (MEMS channel writes), requester 1 is the housekeeping/config path (soft reset, VREF, gain updates issued at runtime). Each requester hands over one SPI word with a one-cycle start pulse. The arbiter buffers one word per requester, serialises the words onto the SPI master's start/busy handshake, and gives requester 0 priority with bounded starvation of requester 1.

---
 rtl/mems_spi_arbiter.sv | 149 ++++++++++++++
 tb/tb_mems_spi_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mems_spi_arbiter.sv
// Two-requester arbiter for the MEMS DAC SPI master: start at T -> busy T+1, grant T+2, spi_start T+3; one word buffered per slot,
// extra starts are dropped. Requester 0 has priority, bounded by MAX_CONSEC. Optional watchdog: MEMS_SPI_ARB_WATCHDOG_EN.
module mems_spi_arbiter #(
  parameter int DATA_W     = 24,
  parameter int MAX_CONSEC = 8,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_start,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_busy,
  input  logic              req1_start,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_busy,
  output logic              spi_start,
  output logic [DATA_W-1:0] spi_data,
  input  logic              spi_busy,
  output logic [1:0]        grant,
  output logic [1:0]        req_drop,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] buf0, buf1;
  logic              vld0, vld1;
  logic [7:0]        consec;
  logic              idle_ok;
  logic              pick1, go, done, wd_fire;
  logic              spi_start_d;
  logic [1:0]        grant_d;
  logic [DATA_W-1:0] spi_data_d;

  assign pick1 = vld1 && (!vld0 || consec == 8'(MAX_CONSEC));
  // idle_ok: the previous cycle was IDLE with the SPI master quiet, so a
  // transfer still running across a reset is never overlapped.
  assign go    = (state == IDLE) && idle_ok && (vld0 || vld1);
  assign done  = ((state == WAIT_DONE) && !spi_busy) || wd_fire;

`ifdef MEMS_SPI_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;

  assign wd_fire = ((state == WAIT_BUSY) || (state == WAIT_DONE)) &&
                   (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_nxt != state || !((state == WAIT_BUSY) || (state == WAIT_DONE)))
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + 1'b1;
      if (wd_fire)
        timeout_err <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign wd_fire        = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (go) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (wd_fire) state_nxt = IDLE;
                 else if (spi_busy) state_nxt = WAIT_DONE;
      WAIT_DONE: if (done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    spi_start_d = (state == ISSUE);
    grant_d     = grant;
    spi_data_d  = spi_data;
    if (go) begin
      grant_d    = pick1 ? 2'b10 : 2'b01;
      spi_data_d = pick1 ? buf1 : buf0;
    end else if (done) begin
      grant_d    = 2'b00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_start <= 1'b0;
      spi_data  <= '0;
      grant     <= 2'b00;
    end else begin
      spi_start <= spi_start_d;
      spi_data  <= spi_data_d;
      grant     <= grant_d;
    end
  end

  // A start on the completion cycle still sees the slot valid and is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld0     <= 1'b0;
      vld1     <= 1'b0;
      buf0     <= '0;
      buf1     <= '0;
      req_drop <= 2'b00;
      idle_ok  <= 1'b0;
    end else begin
      req_drop <= {req1_start & vld1, req0_start & vld0};
      idle_ok  <= (state == IDLE) && !spi_busy;
      if (req0_start && !vld0) begin
        vld0 <= 1'b1;
        buf0 <= req0_data;
      end else if (done && grant[0]) begin
        vld0 <= 1'b0;
      end
      if (req1_start && !vld1) begin
        vld1 <= 1'b1;
        buf1 <= req1_data;
      end else if (done && grant[1]) begin
        vld1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      consec <= 8'd0;
    else if (!vld1 || (go && pick1))
      consec <= 8'd0;
    else if (go && consec != 8'(MAX_CONSEC))
      consec <= consec + 8'd1;
  end

  assign req0_busy = vld0;
  assign req1_busy = vld1;

endmodule

// File: tb/tb_mems_spi_arbiter.sv
// Directed bench for mems_spi_arbiter: per-cycle vector table plus
// hand-written multi-cycle sequences against a simple SPI busy model.
module tb_mems_spi_arbiter;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_start = 1'b0, req1_start = 1'b0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_busy, req1_busy, spi_start, spi_busy, timeout_err;
  logic [DW-1:0] spi_data;
  logic [1:0]    grant, req_drop;

  logic model_en = 1'b0, never_busy = 1'b0, tb_busy = 1'b0, mb = 1'b0;
  int   mcnt = 0, busy_len = 20;

  int n_pass = 0, n_total = 0;
  int n_st, drops0, drops1;
  logic [DW-1:0] st_data [8];
  logic [1:0]    st_grant[8];

  mems_spi_arbiter #(.DATA_W(DW), .MAX_CONSEC(3), .TIMEOUT(50)) dut (
    .clk(clk), .rst(rst),
    .req0_start(req0_start), .req0_data(req0_data), .req0_busy(req0_busy),
    .req1_start(req1_start), .req1_data(req1_data), .req1_busy(req1_busy),
    .spi_start(spi_start), .spi_data(spi_data), .spi_busy(spi_busy),
    .grant(grant), .req_drop(req_drop), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  assign spi_busy = model_en ? mb : tb_busy;

  // SPI master model: busy for busy_len cycles starting the cycle after spi_start.
  always @(posedge clk) begin
    if (!model_en) begin
      mb <= 1'b0; mcnt <= 0;
    end else if (spi_start && !never_busy) begin
      mb <= 1'b1; mcnt <= busy_len - 1;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
    end else begin
      mb <= 1'b0;
    end
  end

  typedef struct {
    logic r0s; logic [DW-1:0] r0d; logic r1s; logic [DW-1:0] r1d; logic busy;
    logic e_r0b; logic e_r1b; logic [1:0] e_grant; logic e_start;
    logic [DW-1:0] e_data; logic [1:0] e_drop;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Inputs change at negedges; returns at the negedge of the cycle after the pulse.
  task automatic pulse(input logic s0, input logic [DW-1:0] d0, input logic s1, input logic [DW-1:0] d1);
    req0_start = s0; req0_data = d0; req1_start = s1; req1_data = d1;
    @(negedge clk);
    req0_start = 1'b0; req1_start = 1'b0;
  endtask

  // Observe ncyc cycles; optionally re-issue requester-0 words as soon as its slot frees.
  task automatic run(input int ncyc, input int reloads);
    n_st = 0; drops0 = 0; drops1 = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (spi_start) begin
        if (n_st < 8) begin st_data[n_st] = spi_data; st_grant[n_st] = grant; end
        n_st++;
      end
      if (req_drop[0]) drops0++;
      if (req_drop[1]) drops1++;
      if (req0_start) req0_start = 1'b0;
      else if (reloads > 0 && !req0_busy) begin
        req0_start = 1'b1; req0_data = 24'h300000 + DW'(reloads); reloads--;
      end
      @(negedge clk);
    end
    req0_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    int rb_fall, sb_fall, gbad, extra, st_cyc;
    logic [DW-1:0] st_d;
    logic seen_high;

    tbl[0] = '{1'b0, 24'h0, 1'b1, 24'h123456, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 24'h000000, 2'b00};
    tbl[1] = '{1'b0, 24'h0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 24'h123456, 2'b00};
    tbl[2] = '{1'b0, 24'h0, 1'b1, 24'hFFFFFF, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 24'h123456, 2'b10};
    tbl[3] = '{1'b0, 24'h0, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 24'h123456, 2'b00};
    tbl[4] = '{1'b0, 24'h0, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 24'h123456, 2'b00};
    tbl[5] = '{1'b0, 24'h0, 1'b1, 24'h0F0F0F, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 24'h123456, 2'b10};
    tbl[6] = '{1'b0, 24'h0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 24'h123456, 2'b00};

    // Reset state
    @(negedge clk);
    chk("rst_spi_start", spi_start, 0);
    chk("rst_spi_data", spi_data, 0);
    chk("rst_grant", grant, 0);
    chk("rst_req0_busy", req0_busy, 0);
    chk("rst_req1_busy", req1_busy, 0);
    chk("rst_req_drop", req_drop, 0);
    chk("rst_timeout_err", timeout_err, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    // Cycle-by-cycle requester-1 transfer with a drop mid-transfer and on the completion cycle
    for (int i = 0; i < 7; i++) begin
      req0_start = tbl[i].r0s; req0_data = tbl[i].r0d;
      req1_start = tbl[i].r1s; req1_data = tbl[i].r1d;
      tb_busy    = tbl[i].busy;
      @(negedge clk);
      chk($sformatf("tbl%0d_req0_busy", i), req0_busy, tbl[i].e_r0b);
      chk($sformatf("tbl%0d_req1_busy", i), req1_busy, tbl[i].e_r1b);
      chk($sformatf("tbl%0d_grant", i), grant, tbl[i].e_grant);
      chk($sformatf("tbl%0d_spi_start", i), spi_start, tbl[i].e_start);
      chk($sformatf("tbl%0d_spi_data", i), spi_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_req_drop", i), req_drop, tbl[i].e_drop);
    end
    req0_start = 1'b0; req1_start = 1'b0; tb_busy = 1'b0;
    model_en = 1'b1;
    idle(4);

    // Single requester-0 word, SPI busy for 20 cycles
    busy_len = 20;
    pulse(1'b1, 24'hA5A5A5, 1'b0, 24'h0);
    chk("a_busy_t1", req0_busy, 1);
    chk("a_grant_t1", grant, 2'b00);
    @(negedge clk);
    chk("a_grant_t2", grant, 2'b01);
    chk("a_start_t2", spi_start, 0);
    @(negedge clk);
    chk("a_start_t3", spi_start, 1);
    chk("a_data_t3", spi_data, 24'hA5A5A5);
    rb_fall = -1; sb_fall = -1; gbad = 0; extra = 0; seen_high = 1'b0;
    for (int k = 4; k <= 60; k++) begin
      @(negedge clk);
      if (spi_start) extra++;
      if (req0_busy && grant != 2'b01) gbad++;
      if (rb_fall < 0 && !req0_busy) rb_fall = k;
      if (sb_fall < 0 && seen_high && !spi_busy) sb_fall = k;
      if (spi_busy) seen_high = 1'b1;
    end
    chk("a_spi_busy_fall_cycle", sb_fall, 24);
    chk("a_req0_busy_fall_cycle", rb_fall, 25);
    chk("a_grant_held", gbad, 0);
    chk("a_extra_starts", extra, 0);
    chk("a_grant_end", grant, 2'b00);

    // Both starts in the same cycle
    busy_len = 5;
    pulse(1'b1, 24'h111111, 1'b1, 24'h222222);
    run(80, 0);
    chk("b_starts", n_st, 2);
    chk("b_grant0", st_grant[0], 2'b01);
    chk("b_data0", st_data[0], 24'h111111);
    chk("b_grant1", st_grant[1], 2'b10);
    chk("b_data1", st_data[1], 24'h222222);
    chk("b_drops", drops0 + drops1, 0);
    idle(3);

    // Starvation bound, MAX_CONSEC=3, requester 0 reloads after every completion
    busy_len = 3;
    pulse(1'b1, 24'h100001, 1'b1, 24'h200002);
    run(200, 3);
    chk("c_starts", n_st, 5);
    chk("c_grant0", st_grant[0], 2'b01);
    chk("c_grant1", st_grant[1], 2'b01);
    chk("c_grant2", st_grant[2], 2'b01);
    chk("c_grant3", st_grant[3], 2'b10);
    chk("c_grant4", st_grant[4], 2'b01);
    chk("c_req1_served", st_data[3], 24'h200002);
    chk("c_drops", drops0 + drops1, 0);
    idle(3);

    // Second requester-0 start while its slot is busy
    busy_len = 5;
    pulse(1'b1, 24'hC0FFEE, 1'b0, 24'h0);
    chk("d_busy", req0_busy, 1);
    pulse(1'b1, 24'hBADBAD, 1'b0, 24'h0);
    run(60, 0);
    chk("d_drops0", drops0, 1);
    chk("d_drops1", drops1, 0);
    chk("d_starts", n_st, 1);
    chk("d_data", st_data[0], 24'hC0FFEE);
    chk("d_busy_end", req0_busy, 0);
    idle(3);

    // Reset during WAIT_DONE with the SPI master still busy
    busy_len = 20;
    pulse(1'b0, 24'h0, 1'b1, 24'h5A5A5A);
    idle(10);
    pulse(1'b1, 24'h444444, 1'b0, 24'h0);
    chk("e_pre_grant", grant, 2'b10);
    chk("e_pre_busy0", req0_busy, 1);
    rst = 1'b1;
    #1;
    chk("e_rst_grant", grant, 2'b00);
    chk("e_rst_spi_data", spi_data, 0);
    chk("e_rst_req0_busy", req0_busy, 0);
    chk("e_rst_req1_busy", req1_busy, 0);
    chk("e_rst_spi_start", spi_start, 0);
    chk("e_rst_spi_busy_high", spi_busy, 1);
    @(negedge clk);
    rst = 1'b0;
    pulse(1'b1, 24'h777777, 1'b0, 24'h0);
    sb_fall = -1; st_cyc = -1; st_d = '0;
    for (int c = 0; c < 60; c++) begin
      if (sb_fall < 0 && !spi_busy) sb_fall = c;
      if (spi_start && st_cyc < 0) begin st_cyc = c; st_d = spi_data; end
      @(negedge clk);
    end
    chk("e_spi_busy_fell", sb_fall >= 0, 1);
    chk("e_start_after_quiet", st_cyc, sb_fall + 3);
    chk("e_start_data", st_d, 24'h777777);
    idle(3);

`ifdef MEMS_SPI_ARB_WATCHDOG_EN
    // SPI master never responds: watchdog after 50 cycles in WAIT_BUSY
    never_busy = 1'b1;
    pulse(1'b1, 24'h0A0A0A, 1'b0, 24'h0);
    repeat (51) @(negedge clk);
    chk("f_no_err_yet", timeout_err, 0);
    chk("f_grant_held", grant, 2'b01);
    @(negedge clk);
    chk("f_timeout_err", timeout_err, 1);
    chk("f_grant_clear", grant, 2'b00);
    chk("f_slot_cleared", req0_busy, 0);
    never_busy = 1'b0;
    idle(2);
    pulse(1'b0, 24'h0, 1'b1, 24'h0B0B0B);
    run(60, 0);
    chk("f_starts", n_st, 1);
    chk("f_grant", st_grant[0], 2'b10);
    chk("f_data", st_data[0], 24'h0B0B0B);
    chk("f_req1_done", req1_busy, 0);
    chk("f_err_sticky", timeout_err, 1);
`else
    chk("f_timeout_err_tied", timeout_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
